// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI-style burst slave backed by a synchronous 256-bit RAM.
// Define AXI_MEM_STALL_EN to throttle wready/rvalid from a free-running 16-bit LFSR.
module axi_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic         axi_clk,
  input  logic         rst,
  input  logic [7:0]   aid,
  input  logic [31:0]  aaddr,
  input  logic [7:0]   alen,
  input  logic [2:0]   asize,
  input  logic [1:0]   aburst,
  input  logic [1:0]   alock,
  input  logic         atype,
  input  logic         avalid,
  output logic         aready,
  input  logic [7:0]   wid,
  input  logic [255:0] wdata,
  input  logic [31:0]  wstrb,
  input  logic         wlast,
  input  logic         wvalid,
  output logic         wready,
  output logic [7:0]   rid,
  output logic [255:0] rdata,
  output logic         rlast,
  output logic         rvalid,
  input  logic         rready,
  output logic [1:0]   rresp,
  output logic [7:0]   bid,
  output logic         bvalid,
  input  logic         bready,
  output logic         wlast_err,
  output logic [15:0]  burst_cnt
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {StIdle, StWData, StWResp, StRData} state_e;

  state_e       state_q, state_d;
  logic         aready_q, aready_d;
  logic [7:0]   id_q, id_d, len_q, len_d, wbeat_q, wbeat_d;
  logic         bad_q, bad_d, wlast_err_q, wlast_err_d;
  idx_t         widx_q, widx_d, ridx_q, ridx_d;
  logic [8:0]   fetch_left_q, fetch_left_d;
  logic         inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic         rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [255:0] rdata_q, rdata_d, skid_data_q, skid_data_d;
  logic         skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [15:0]  burst_cnt_q, burst_cnt_d;

  logic         a_hs, w_hs, r_hs, b_hs, w_last_beat;
  logic         rd_first, rd_issue, ram_re, ram_we;
  idx_t         ram_raddr;
  logic [255:0] ram_rdata_q;
  logic [255:0] mem_q [Depth];
  logic [1:0]   occ_after;
  logic         stall_w, stall_r, rvalid_vis;
  logic         unused_ok;

  assign unused_ok = ^{alock, wid, aaddr[31:5+DEPTH_LOG2], aaddr[4:0]};

`ifdef AXI_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        shown_q, shown_d;

  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // A beat that has been presented stays presented until it is taken.
    shown_d = rvalid_vis & ~rready;
  end

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      lfsr_q  <= LFSR_SEED;
      shown_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      shown_q <= shown_d;
    end
  end

  assign stall_w = lfsr_q[0];
  assign stall_r = lfsr_q[1] & ~shown_q;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign stall_w     = 1'b0;
  assign stall_r     = 1'b0;
`endif

  assign rvalid_vis  = rvalid_q & ~stall_r;
  assign a_hs        = avalid & aready_q;
  assign w_hs        = wvalid & wready;
  assign r_hs        = rvalid_vis & rready;
  assign b_hs        = bvalid & bready;
  assign w_last_beat = (wbeat_q == len_q);

  // Read prefetch: output register + skid + one RAM read in flight never exceed two entries.
  assign occ_after = {1'b0, rvalid_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q} - {1'b0, r_hs};
  assign rd_first  = a_hs & ~atype;
  assign rd_issue  = (state_q == StRData) && (fetch_left_q != 9'd0) && (occ_after < 2'd2);
  assign ram_re    = rd_first | rd_issue;
  assign ram_raddr = rd_first ? aaddr[5 +: DEPTH_LOG2] : ridx_q;
  assign ram_we    = w_hs & ~bad_q;

  always_ff @(posedge axi_clk) begin
    if (ram_we) begin
      for (int i = 0; i < 32; i++) begin
        if (wstrb[i]) mem_q[widx_q][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (ram_re) ram_rdata_q <= mem_q[ram_raddr];
  end

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (a_hs) state_d = atype ? StWData : StRData;
      StWData: if (w_hs && w_last_beat) state_d = StWResp;
      StWResp: if (bready) state_d = StIdle;
      StRData: if (r_hs && rlast_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wready = 1'b0;
    bvalid = 1'b0;
    unique case (state_q)
      StWData: wready = ~stall_w;
      StWResp: bvalid = 1'b1;
      default: ;
    endcase
    aready_d = (state_d == StIdle);
  end

  always_comb begin
    id_d            = id_q;
    len_d           = len_q;
    bad_d           = bad_q;
    widx_d          = widx_q;
    wbeat_d         = wbeat_q;
    ridx_d          = ridx_q;
    fetch_left_d    = fetch_left_q;
    wlast_err_d     = wlast_err_q;
    burst_cnt_d     = burst_cnt_q;
    inflight_d      = ram_re;
    inflight_last_d = rd_first ? (alen == 8'd0) : (fetch_left_q == 9'd1);
    if (a_hs) begin
      id_d         = aid;
      len_d        = alen;
      bad_d        = (asize != 3'd5) || (aburst != 2'b01);
      widx_d       = aaddr[5 +: DEPTH_LOG2];
      wbeat_d      = 8'd0;
      ridx_d       = aaddr[5 +: DEPTH_LOG2] + 1'b1;
      fetch_left_d = {1'b0, alen};
    end
    if (rd_issue) begin
      ridx_d       = ridx_q + 1'b1;
      fetch_left_d = fetch_left_q - 9'd1;
    end
    if (w_hs) begin
      widx_d  = widx_q + 1'b1;
      wbeat_d = wbeat_q + 8'd1;
      if (wlast != w_last_beat) wlast_err_d = 1'b1;
    end
    if (b_hs || (r_hs && rlast_q)) burst_cnt_d = burst_cnt_q + 16'd1;
  end

  always_comb begin
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rdata_d     = rdata_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (!rvalid_q || r_hs) begin
      if (skid_vld_q) begin
        rvalid_d    = 1'b1;
        rdata_d     = skid_data_q;
        rlast_d     = skid_last_q;
        skid_vld_d  = inflight_q;
        skid_data_d = ram_rdata_q;
        skid_last_d = inflight_last_q;
      end else if (inflight_q) begin
        rvalid_d = 1'b1;
        rdata_d  = ram_rdata_q;
        rlast_d  = inflight_last_q;
      end else begin
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
      end
    end else if (inflight_q) begin
      skid_vld_d  = 1'b1;
      skid_data_d = ram_rdata_q;
      skid_last_d = inflight_last_q;
    end
  end

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      aready_q        <= 1'b0;
      id_q            <= '0;
      len_q           <= '0;
      bad_q           <= 1'b0;
      widx_q          <= '0;
      wbeat_q         <= '0;
      ridx_q          <= '0;
      fetch_left_q    <= '0;
      wlast_err_q     <= 1'b0;
      burst_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rvalid_q        <= 1'b0;
      rlast_q         <= 1'b0;
      rdata_q         <= '0;
      skid_vld_q      <= 1'b0;
      skid_data_q     <= '0;
      skid_last_q     <= 1'b0;
    end else begin
      aready_q        <= aready_d;
      id_q            <= id_d;
      len_q           <= len_d;
      bad_q           <= bad_d;
      widx_q          <= widx_d;
      wbeat_q         <= wbeat_d;
      ridx_q          <= ridx_d;
      fetch_left_q    <= fetch_left_d;
      wlast_err_q     <= wlast_err_d;
      burst_cnt_q     <= burst_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      rvalid_q        <= rvalid_d;
      rlast_q         <= rlast_d;
      rdata_q         <= rdata_d;
      skid_vld_q      <= skid_vld_d;
      skid_data_q     <= skid_data_d;
      skid_last_q     <= skid_last_d;
    end
  end

  assign aready    = aready_q;
  assign rid       = id_q;
  assign bid       = id_q;
  assign rresp     = {bad_q, 1'b0};
  assign rdata     = rdata_q;
  assign rlast     = rlast_q;
  assign rvalid    = rvalid_vis;
  assign wlast_err = wlast_err_q;
  assign burst_cnt = burst_cnt_q;

endmodule
